rtc_bus_responder: RTL and testbench
====================================

Name: rtc_bus_responder

Overview:
- Synthesizable bus-side responder for the multiplexed address/data RTC interface driven by the control generator (CS, RD, WR, A_D).
- Decodes address and data cycles, holds a 16-byte register file and returns read data on a split data bus.
- Includes a BCD seconds/minutes/hours counter advanced by an external 1 Hz tick.
- Used as the device-side model in system benches and as a synthesizable RTC stand-in on the FPGA.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizer on CS/RD/WR/A_D and on dato_in (min 2).
- ADDR_BASE, 8'h20, upper nibble match for valid register addresses (valid range ADDR_BASE..ADDR_BASE+15).

Ports:
- reloj  in  1  system clock, all logic on rising edge
- resetM  in  1  asynchronous, active-high reset
- CS  in  1  chip select, active low
- RD  in  1  read strobe, active low
- WR  in  1  write strobe, active low
- A_D  in  1  0 = address cycle, 1 = data cycle
- dato_in  in  8  bus value from the controller
- tick_1hz  in  1  single-cycle time-advance pulse, synchronous to reloj
- dato_out  out  8  read data returned to the controller
- dato_oe  out  1  1 while the responder drives the bus
- dir_actual  out  8  last latched address (debug)
- wr_done  out  1  one-cycle pulse when a register write commits

Behaviour:
- Reset values: dato_out=8'h00, dato_oe=0, dir_actual=8'h00, wr_done=0, all 16 registers=8'h00, FSM=IDLE, synchronizer chains cleared (CS/RD/WR sync to 1).
- Reset is honoured in any state, including mid-transfer; dato_oe drops in the same edge.
- Synchronization:
  - CS, RD, WR, A_D and dato_in pass through identical SYNC_STAGES pipelines, so data stays aligned with the strobes.
  - Every decision below uses the synchronized copies (suffix _s).
- FSM states and transitions:
  - IDLE -> ADDR when CS_s=0, A_D_s=0 and a WR_s falling edge occurs.
  - ADDR: on the WR_s rising edge, latch dir_actual=dato_in_s, then go to IDLE.
  - IDLE -> WRITE when CS_s=0, A_D_s=1 and a WR_s falling edge occurs.
  - WRITE: on the WR_s rising edge, commit dato_in_s to the register, pulse wr_done, then go to IDLE.
  - IDLE -> READ when CS_s=0, A_D_s=1 and RD_s=0.
  - READ: dato_oe=1 and dato_out=reg[dir_actual[3:0]], refreshed every cycle. When RD_s=1 or CS_s=1, dato_oe=0 next edge and FSM returns to IDLE.
  - CS_s rising in ADDR or WRITE aborts to IDLE with no latch or commit.
- Latency: register commit occurs SYNC_STAGES+1 reloj edges after raw WR rises; dato_oe asserts SYNC_STAGES+1 edges after raw RD falls.
- Address decode:
  - Valid when dir_actual[7:4]==ADDR_BASE[7:4].
  - Invalid address: reads return 8'h00 (dato_oe still asserts); writes are ignored and wr_done is not pulsed.
- RD and WR low simultaneously: treated as illegal; FSM stays or returns to IDLE, dato_oe=0, no commit.
- Register map (offset): 0 control (bit0 = halt counting), 1 seconds BCD, 2 minutes BCD, 3 hours BCD, 4..15 general-purpose scratch.
- Time counting, on tick_1hz=1 with control bit0=0:
  - seconds +1 BCD; 8'h59 wraps to 8'h00 and carries into minutes.
  - minutes behave the same way and carry into hours.
  - hours: 8'h23 wraps to 8'h00.
  - Invalid BCD values are forced to 8'h00 on the next tick.
- Tick coinciding with a write commit to offset 1..3: the write wins and that tick is discarded entirely. A commit to offsets 0 or 4..15 does not block the tick.

Decomposition:
- Shared package rtc_bus_pkg:
  - register offset constants (REG_CTRL, REG_SEG, REG_MIN, REG_HORA);
  - FSM state encoding (IDLE, ADDR, WRITE, READ);
  - BCD limit constants 8'h59 and 8'h23.
- One natural sub-module: bcd_contador. It is a 2-digit BCD incrementer with programmable wrap limit, carry out and synchronous load, instantiated three times.

Test Plan:
- Reset mid-read: assert resetM while dato_oe=1 -> dato_oe=0, dato_out=8'h00 and FSM=IDLE on the reset edge.
- Address write: A_D=0, CS=0, WR low 10 cycles with dato_in=8'h22 -> dir_actual=8'h22 exactly SYNC_STAGES+1 edges after WR rises, wr_done stays 0.
- Data write then read back: address 8'h24, data 8'hA5 -> wr_done single pulse. Then A_D=1, RD low -> dato_oe=1 and dato_out=8'hA5 within SYNC_STAGES+1 edges; dato_oe=0 after RD rises.
- Invalid address: address 8'h31, write 8'h77, then read -> no wr_done, dato_out=8'h00, scratch registers unchanged.
- Rollover: preset hours=8'h23, minutes=8'h59, seconds=8'h59, then one tick_1hz -> all three read 8'h00. With control bit0=1, a tick leaves the values unchanged.
- Write/tick collision: commit seconds=8'h10 on the same edge as tick_1hz -> seconds reads 8'h10, not 8'h11.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus responder: register map, FSM encoding
// and BCD wrap limits for the time-of-day counters.
package rtc_bus_pkg;

  // Register offsets inside the 16-byte window
  localparam logic [3:0] REG_CTRL = 4'd0;
  localparam logic [3:0] REG_SEG  = 4'd1;
  localparam logic [3:0] REG_MIN  = 4'd2;
  localparam logic [3:0] REG_HORA = 4'd3;

  // Wrap limits for the BCD counters
  localparam logic [7:0] LIM_SEG  = 8'h59;
  localparam logic [7:0] LIM_MIN  = 8'h59;
  localparam logic [7:0] LIM_HORA = 8'h23;

  // Bus-side protocol states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } bus_state_t;

  // True when both nibbles hold decimal digits
  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_bus_responder_bcd_contador.sv
// Two-digit BCD counter with a fixed wrap limit, carry out and a
// synchronous load that takes priority over counting.
module bcd_contador
  import rtc_bus_pkg::*;
#(
  parameter logic [7:0] LIMIT = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       tick,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] next_val;
  logic       at_limit;
  logic       in_range;

  // Next BCD value, range check and carry toward the next digit pair
  always_comb begin
    in_range = bcd_valid(value) && (value <= LIMIT);
    at_limit = (value == LIMIT);
    if (value[3:0] == 4'd9) begin
      next_val = {value[7:4] + 4'd1, 4'd0};
    end else begin
      next_val = {value[7:4], value[3:0] + 4'd1};
    end
    carry = inc && at_limit && !load;
  end

  // Load wins; otherwise a tick cleans up garbage and an increment advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 8'h00;
    end else if (load) begin
      value <= load_val;
    end else if (tick && !in_range) begin
      value <= 8'h00;
    end else if (inc) begin
      value <= at_limit ? 8'h00 : next_val;
    end
  end

endmodule

// File: rtl/rtc_bus_responder.sv
// Device-side responder for the multiplexed address/data RTC bus: strobe
// synchronizers, protocol FSM, 16-byte register file and BCD time counter.
module rtc_bus_responder
  import rtc_bus_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ADDR_BASE   = 8'h20
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       CS,
  input  logic       RD,
  input  logic       WR,
  input  logic       A_D,
  input  logic [7:0] dato_in,
  input  logic       tick_1hz,
  output logic [7:0] dato_out,
  output logic       dato_oe,
  output logic [7:0] dir_actual,
  output logic       wr_done
);

  logic [SYNC_STAGES-1:0] cs_pipe;
  logic [SYNC_STAGES-1:0] rd_pipe;
  logic [SYNC_STAGES-1:0] wr_pipe;
  logic [SYNC_STAGES-1:0] ad_pipe;
  logic [7:0]             data_pipe [SYNC_STAGES];

  logic       cs_s, rd_s, wr_s, ad_s;
  logic [7:0] data_s;
  logic       wr_prev;
  logic       wr_fall, wr_rise, illegal;

  bus_state_t state, next_state;
  logic       latch_addr, commit_wr;

  logic [7:0] reg_file [16];
  logic [3:0] off;
  logic       addr_valid;
  logic       time_write;
  logic       tick_ok;
  logic [7:0] rdata;

  logic [7:0] seg_val, min_val, hora_val;
  logic       seg_carry, min_carry, hora_carry_unused;

  assign cs_s   = cs_pipe[SYNC_STAGES-1];
  assign rd_s   = rd_pipe[SYNC_STAGES-1];
  assign wr_s   = wr_pipe[SYNC_STAGES-1];
  assign ad_s   = ad_pipe[SYNC_STAGES-1];
  assign data_s = data_pipe[SYNC_STAGES-1];

  assign wr_fall    = wr_prev && !wr_s;
  assign wr_rise    = !wr_prev && wr_s;
  assign illegal    = !rd_s && !wr_s;
  assign off        = dir_actual[3:0];
  assign addr_valid = (dir_actual[7:4] == ADDR_BASE[7:4]);

  // Identical-depth synchronizers keep the data aligned with its strobes
  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      cs_pipe <= '1;
      rd_pipe <= '1;
      wr_pipe <= '1;
      ad_pipe <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_pipe[i] <= 8'h00;
      end
      wr_prev <= 1'b1;
    end else begin
      cs_pipe      <= {cs_pipe[SYNC_STAGES-2:0], CS};
      rd_pipe      <= {rd_pipe[SYNC_STAGES-2:0], RD};
      wr_pipe      <= {wr_pipe[SYNC_STAGES-2:0], WR};
      ad_pipe      <= {ad_pipe[SYNC_STAGES-2:0], A_D};
      data_pipe[0] <= dato_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_pipe[i] <= data_pipe[i-1];
      end
      wr_prev <= wr_s;
    end
  end

  // Protocol FSM state register
  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; RD and WR low together always falls back to IDLE
  always_comb begin
    next_state = state;
    latch_addr = 1'b0;
    commit_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_s && !illegal) begin
          if (wr_fall && !ad_s) begin
            next_state = ADDR;
          end else if (wr_fall && ad_s) begin
            next_state = WRITE;
          end else if (!rd_s && ad_s) begin
            next_state = READ;
          end
        end
      end
      ADDR: begin
        if (cs_s || illegal) begin
          next_state = IDLE;
        end else if (wr_rise) begin
          latch_addr = 1'b1;
          next_state = IDLE;
        end
      end
      WRITE: begin
        if (cs_s || illegal) begin
          next_state = IDLE;
        end else if (wr_rise) begin
          commit_wr  = addr_valid;
          next_state = IDLE;
        end
      end
      READ: begin
        if (cs_s || rd_s || !wr_s) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A write to a time register discards the coinciding tick entirely
  always_comb begin
    time_write = commit_wr && ((off == REG_SEG) || (off == REG_MIN) || (off == REG_HORA));
    tick_ok    = tick_1hz && !reg_file[REG_CTRL][0] && !time_write;
  end

  // Read mux: time registers come from the counters, the rest from the file
  always_comb begin
    rdata = 8'h00;
    if (addr_valid) begin
      case (off)
        REG_SEG:  rdata = seg_val;
        REG_MIN:  rdata = min_val;
        REG_HORA: rdata = hora_val;
        default:  rdata = reg_file[off];
      endcase
    end
  end

  // Address latch, control/scratch storage and the write-commit pulse
  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      dir_actual <= 8'h00;
      wr_done    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        reg_file[i] <= 8'h00;
      end
    end else begin
      wr_done <= commit_wr;
      if (latch_addr) begin
        dir_actual <= data_s;
      end
      if (commit_wr && !time_write) begin
        reg_file[off] <= data_s;
      end
    end
  end

  // Bus drive: enable and data are refreshed every cycle spent in READ
  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      dato_oe  <= 1'b0;
      dato_out <= 8'h00;
    end else begin
      dato_oe  <= (next_state == READ);
      dato_out <= (next_state == READ) ? rdata : 8'h00;
    end
  end

  bcd_contador #(.LIMIT(LIM_SEG)) u_seg (
    .clk      (reloj),
    .rst      (resetM),
    .load     (commit_wr && (off == REG_SEG)),
    .load_val (data_s),
    .tick     (tick_ok),
    .inc      (tick_ok),
    .value    (seg_val),
    .carry    (seg_carry)
  );

  bcd_contador #(.LIMIT(LIM_MIN)) u_min (
    .clk      (reloj),
    .rst      (resetM),
    .load     (commit_wr && (off == REG_MIN)),
    .load_val (data_s),
    .tick     (tick_ok),
    .inc      (seg_carry),
    .value    (min_val),
    .carry    (min_carry)
  );

  bcd_contador #(.LIMIT(LIM_HORA)) u_hora (
    .clk      (reloj),
    .rst      (resetM),
    .load     (commit_wr && (off == REG_HORA)),
    .load_val (data_s),
    .tick     (tick_ok),
    .inc      (min_carry),
    .value    (hora_val),
    .carry    (hora_carry_unused)
  );

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with a read-data scoreboard queue.
module tb_rtc_bus_responder;

  localparam int SYNC = 2;

  logic       reloj;
  logic       resetM;
  logic       CS, RD, WR, A_D;
  logic [7:0] dato_in;
  logic       tick_1hz;
  logic [7:0] dato_out;
  logic       dato_oe;
  logic [7:0] dir_actual;
  logic       wr_done;

  int         vectors;
  int         miscompares;
  logic [7:0] model_dir;
  logic [7:0] exp_rd_q [$];

  rtc_bus_responder #(
    .SYNC_STAGES (SYNC),
    .ADDR_BASE   (8'h20)
  ) dut (
    .reloj      (reloj),
    .resetM     (resetM),
    .CS         (CS),
    .RD         (RD),
    .WR         (WR),
    .A_D        (A_D),
    .dato_in    (dato_in),
    .tick_1hz   (tick_1hz),
    .dato_out   (dato_out),
    .dato_oe    (dato_oe),
    .dir_actual (dir_actual),
    .wr_done    (wr_done)
  );

  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  // One address (ad=0) or data (ad=1) bus write; optional tick on the commit edge
  task automatic applyStimulus(input logic ad, input logic [7:0] data, input logic tick_flag,
                               input logic [7:0] exp_pulses);
    logic [7:0] pulses;
    pulses = 8'h00;
    @(negedge reloj);
    CS = 1'b0; A_D = ad; dato_in = data; RD = 1'b1; WR = 1'b1;
    @(negedge reloj);
    WR = 1'b0;
    repeat (4) begin
      @(negedge reloj);
      if (wr_done) pulses++;
    end
    WR = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge reloj);
      if (wr_done) pulses++;
      if (!ad && i == SYNC) checkOutput("addr_hold", dir_actual, model_dir);
      if (!ad && i == SYNC + 1) checkOutput("addr_latch", dir_actual, data);
      tick_1hz = (i == SYNC) ? tick_flag : 1'b0;
    end
    CS = 1'b1; A_D = 1'b0;
    repeat (3) @(negedge reloj);
    checkOutput(ad ? "data_wr_done" : "addr_wr_done", pulses, exp_pulses);
    if (!ad) model_dir = data;
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [7:0] data, input logic tick_flag,
                          input logic [7:0] exp_pulses);
    applyStimulus(1'b0, addr, 1'b0, 8'h00);
    applyStimulus(1'b1, data, tick_flag, exp_pulses);
  endtask

  // Read cycle; the expected value is popped when dato_oe appears
  task automatic readBack(input string tag);
    int         waited;
    logic       seen;
    logic [7:0] expected;
    @(negedge reloj);
    CS = 1'b0; A_D = 1'b1; RD = 1'b1; WR = 1'b1;
    @(negedge reloj);
    RD = 1'b0;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 10) begin
      @(negedge reloj);
      waited++;
      if (dato_oe === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, "_oe_latency"}, 8'(waited), 8'(SYNC + 1));
    if (exp_rd_q.size() > 0) begin
      expected = exp_rd_q.pop_front();
      checkOutput({tag, "_data"}, dato_out, expected);
    end else begin
      checkOutput({tag, "_queue_empty"}, 8'h01, 8'h00);
    end
    RD = 1'b1;
    repeat (SYNC + 1) @(negedge reloj);
    checkOutput({tag, "_oe_drop"}, {7'b0, dato_oe}, 8'h00);
    CS = 1'b1;
    repeat (2) @(negedge reloj);
  endtask

  task automatic readReg(input string tag, input logic [7:0] addr, input logic [7:0] expected);
    applyStimulus(1'b0, addr, 1'b0, 8'h00);
    exp_rd_q.push_back(expected);
    readBack(tag);
  endtask

  task automatic pulseTick();
    @(negedge reloj);
    tick_1hz = 1'b1;
    @(negedge reloj);
    tick_1hz = 1'b0;
    repeat (2) @(negedge reloj);
  endtask

  initial begin
    int   oe_seen;
    int   done_seen;
    int   waited;
    vectors     = 0;
    miscompares = 0;
    model_dir   = 8'h00;
    resetM = 1'b1; CS = 1'b1; RD = 1'b1; WR = 1'b1; A_D = 1'b0;
    dato_in = 8'h00; tick_1hz = 1'b0;

    // Reset state
    repeat (3) @(negedge reloj);
    checkOutput("rst_dato_out", dato_out, 8'h00);
    checkOutput("rst_dato_oe", {7'b0, dato_oe}, 8'h00);
    checkOutput("rst_dir_actual", dir_actual, 8'h00);
    checkOutput("rst_wr_done", {7'b0, wr_done}, 8'h00);
    resetM = 1'b0;
    repeat (2) @(negedge reloj);

    // Address cycle alone
    applyStimulus(1'b0, 8'h22, 1'b0, 8'h00);

    // Data write and read back of a scratch register
    writeReg(8'h24, 8'hA5, 1'b0, 8'h01);
    exp_rd_q.push_back(8'hA5);
    readBack("scratch_a5");

    // Invalid address: write ignored, read returns zero
    writeReg(8'h31, 8'h77, 1'b0, 8'h00);
    exp_rd_q.push_back(8'h00);
    readBack("invalid_rd");
    readReg("scratch_kept", 8'h24, 8'hA5);
    readReg("seg_untouched", 8'h21, 8'h00);

    // Full rollover 23:59:59 -> 00:00:00
    writeReg(8'h23, 8'h23, 1'b0, 8'h01);
    writeReg(8'h22, 8'h59, 1'b0, 8'h01);
    writeReg(8'h21, 8'h59, 1'b0, 8'h01);
    pulseTick();
    readReg("roll_seg", 8'h21, 8'h00);
    readReg("roll_min", 8'h22, 8'h00);
    readReg("roll_hora", 8'h23, 8'h00);

    // Halt bit freezes counting
    writeReg(8'h21, 8'h45, 1'b0, 8'h01);
    writeReg(8'h20, 8'h01, 1'b0, 8'h01);
    pulseTick();
    readReg("halt_seg", 8'h21, 8'h45);
    writeReg(8'h20, 8'h00, 1'b0, 8'h01);
    pulseTick();
    readReg("run_seg", 8'h21, 8'h46);

    // Tick colliding with a time-register write is discarded
    writeReg(8'h21, 8'h10, 1'b1, 8'h01);
    readReg("collide_seg", 8'h21, 8'h10);
    // Tick colliding with a scratch write still counts
    writeReg(8'h24, 8'h5C, 1'b1, 8'h01);
    readReg("scratch_tick_seg", 8'h21, 8'h11);
    readReg("scratch_5c", 8'h24, 8'h5C);

    // BCD digit carry, invalid value cleanup, seconds-to-minutes carry
    writeReg(8'h21, 8'h09, 1'b0, 8'h01);
    pulseTick();
    readReg("bcd_carry", 8'h21, 8'h10);
    writeReg(8'h21, 8'h5A, 1'b0, 8'h01);
    pulseTick();
    readReg("bcd_invalid", 8'h21, 8'h00);
    writeReg(8'h21, 8'h59, 1'b0, 8'h01);
    pulseTick();
    readReg("min_carry_seg", 8'h21, 8'h00);
    readReg("min_carry_min", 8'h22, 8'h01);

    // RD and WR low together: no drive, no commit
    applyStimulus(1'b0, 8'h24, 1'b0, 8'h00);
    oe_seen = 0;
    done_seen = 0;
    @(negedge reloj);
    CS = 1'b0; A_D = 1'b1; dato_in = 8'h11;
    @(negedge reloj);
    RD = 1'b0; WR = 1'b0;
    repeat (6) begin
      @(negedge reloj);
      if (dato_oe) oe_seen++;
      if (wr_done) done_seen++;
    end
    RD = 1'b1; WR = 1'b1;
    repeat (6) begin
      @(negedge reloj);
      if (dato_oe) oe_seen++;
      if (wr_done) done_seen++;
    end
    CS = 1'b1;
    repeat (2) @(negedge reloj);
    checkOutput("illegal_oe", 8'(oe_seen), 8'h00);
    checkOutput("illegal_wr_done", 8'(done_seen), 8'h00);
    readReg("illegal_kept", 8'h24, 8'h5C);

    // Reset in the middle of a read
    applyStimulus(1'b0, 8'h24, 1'b0, 8'h00);
    @(negedge reloj);
    CS = 1'b0; A_D = 1'b1;
    @(negedge reloj);
    RD = 1'b0;
    waited = 0;
    while (dato_oe !== 1'b1 && waited < 10) begin
      @(negedge reloj);
      waited++;
    end
    checkOutput("midread_oe", {7'b0, dato_oe}, 8'h01);
    checkOutput("midread_data", dato_out, 8'h5C);
    resetM = 1'b1;
    #1;
    checkOutput("midrst_dato_oe", {7'b0, dato_oe}, 8'h00);
    checkOutput("midrst_dato_out", dato_out, 8'h00);
    checkOutput("midrst_dir", dir_actual, 8'h00);
    @(negedge reloj);
    RD = 1'b1; CS = 1'b1;
    @(negedge reloj);
    resetM = 1'b0;
    model_dir = 8'h00;
    repeat (2) @(negedge reloj);
    readReg("post_rst_scratch", 8'h24, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
